// File: rtl/encoder_8x3_seq_if.sv
// Output-side bundle of the 8-to-3 sequential encoder: request
// capture inputs plus the valid/ready index handshake.
interface encoder_8x3_seq_if;
   logic       EN;
   logic [7:0] D;
   logic       ready;
   logic       valid;
   logic [2:0] Y;
   logic [7:0] pending;

   modport master (
      output EN, D, ready,
      input  valid, Y, pending
   );

   modport slave (
      input  EN, D, ready,
      output valid, Y, pending
   );
endinterface

// File: rtl/encoder_8x3_seq.sv
// Registered 8-to-3 priority encoder: requests merge into a pending
// register and drain one index per accepted valid/ready transfer.
module encoder_8x3_seq #(
   parameter bit PRIO_HIGH = 1'b1
) (
   input logic              clk,
   input logic              rst_n,
   encoder_8x3_seq_if.slave bus
);
   logic [7:0] pendingQ;
   logic [7:0] pendingNext;
   logic [7:0] clrMask;
   logic       validQ;
   logic [2:0] yQ;
   logic [2:0] yNext;
   logic       accept;
   logic       outLoad;

   function automatic logic [2:0] priorityIndex(
      input logic [7:0] req
   );
      logic [2:0] idx;
      idx = '0;
      // Later hits overwrite earlier ones, so scan toward the winner.
      for (int i = 0; i < 8; i++) begin
         if (PRIO_HIGH) begin
            if (req[i]) idx = 3'(i);
         end else begin
            if (req[7-i]) idx = 3'(7 - i);
         end
      end
      return idx;
   endfunction

   always_comb begin
      accept      = validQ & bus.ready;
      clrMask     = accept ? (8'd1 << yQ) : 8'h00;
      // OR-ing the new requests last lets a set beat a same-bit clear.
      pendingNext = (pendingQ & ~clrMask)
                  | (bus.EN ? bus.D : 8'h00);
      outLoad     = !validQ | bus.ready;
      yNext       = priorityIndex(pendingNext);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pendingQ <= 8'h00;
         validQ   <= 1'b0;
         yQ       <= 3'b000;
      end else begin
         pendingQ <= pendingNext;
         if (outLoad) begin
            validQ <= |pendingNext;
            yQ     <= yNext;
         end
      end
   end

   assign bus.valid   = validQ;
   assign bus.Y       = yQ;
   assign bus.pending = pendingQ;
endmodule

// File: doc/encoder_8x3_seq.md
Name: encoder_8x3_seq

Overview:
- Registered 8-to-3 priority encoder: the inverse of the team's 3x8 decoder.
- Collects one-hot or multi-hot request lines into a pending register and emits one 3-bit index per accepted transfer, highest priority first.
- Uses a valid/ready handshake on the output side.
- Sits in front of decoder_3x8 so an index consumed downstream can be re-expanded to a one-hot strobe.

Parameters:
- PRIO_HIGH, 1, 1: D[7] has highest priority; 0: D[0] has highest priority.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- EN  input  1  capture enable; D is ignored when 0
- D  input  8  request lines, sampled on clk when EN=1
- ready  input  1  downstream accepts Y this cycle when valid=1
- valid  output  1  Y holds a pending request index
- Y  output  3  encoded index of the request being offered
- pending  output  8  current pending-request register (for debug and verification)

Behaviour:
- Single clock domain; all state updates on rising clk edge.
- Reset:
  - rst_n=0 sampled at an edge forces pending=8'h00, valid=0, Y=3'b000.
  - Reset overrides EN/D/ready in the same cycle.
  - Reset mid-transfer drops all pending requests and the offered index.
- accept = valid & ready.
- clr_mask = accept ? (8'b1 << Y) : 8'h00.
- pending_next = (pending & ~clr_mask) | (EN ? D : 8'h00).
- Simultaneous clear and set of the same bit: the set wins, so the bit stays pending as a new request.
- Repeated D on an already-pending bit merges; there is no counting.
- Output register loads only when (!valid | ready):
  - valid <= |pending_next.
  - Y <= priority_index(pending_next), or 3'b000 if none.
- While valid=1 and ready=0, Y and valid are held stable, even if a higher-priority request arrives; that request waits in pending.
- priority_index:
  - PRIO_HIGH=1: highest set bit.
  - PRIO_HIGH=0: lowest set bit.
- Latency: a request sampled at edge k appears on valid/Y after edge k (1 cycle), provided the output register is free or being accepted.
- Throughput: one index per cycle while ready=1 and requests remain.
- The offered bit remains set in pending until accepted. It is cleared on the accept edge, and the next index is loaded on the same edge (no bubble).
- Empty: valid=0, Y=3'b000; ready is ignored.
- All 8 pending: drains in 8 accepted cycles in priority order.
- EN=0: D has no effect; draining continues.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles with EN=1, D=8'hFF → pending=8'h00, valid=0, Y=0; release with EN=0 → remains idle.
- Single request: EN=1, D=8'h20 for 1 cycle, ready=1 → next cycle valid=1, Y=5; following cycle valid=0, pending=8'h00.
- Multi-hot drain: EN=1, D=8'hA5 for 1 cycle, ready=1, PRIO_HIGH=1 → Y sequence 7,5,2,0 on consecutive cycles with valid=1, then valid=0.
- Backpressure stability: D=8'h04 accepted into output with ready=0; then D=8'h80 → Y stays 2 until ready=1. After the accept edge Y=7 with no idle cycle, and pending=8'h80.
- Set/clear collision: valid=1, Y=3, ready=1, EN=1, D=8'h08 in the same cycle → pending bit 3 remains set; the next offered Y=3 again, valid=1.
- Reset mid-drain: pending=8'hFF, drain 3 items, assert rst_n=0 for 1 cycle → valid=0, pending=8'h00 the next cycle; the PRIO_HIGH=0 variant of the drain test yields 0,2,5,7 for 8'hA5.
